// File: rtl/soc_boot_loader_if.sv
// -----------------------------------------------------------------------------
// soc_boot_loader_if
// Purpose : groups the boot loader's two bus-like connections.
//           - the image stream (valid/ready/data) from the external load source
//           - the instruction ROM write port (strobe/address/data)
// Signals : s_valid_i, s_data_i   stream word offered by the source
//           s_ready_o             loader accepts the word this cycle
//           rom_wen_o             one-cycle ROM write strobe
//           rom_addr_o            ROM byte address of the write
//           rom_data_o            ROM write data
// Modports: master - stream source / ROM side (SoC top or test environment)
//           slave  - the boot loader itself
// -----------------------------------------------------------------------------
interface soc_boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              rom_wen_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_o;

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, rom_wen_o, rom_addr_o, rom_data_o
  );

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, rom_wen_o, rom_addr_o, rom_data_o
  );
endinterface

// File: rtl/soc_boot_loader.sv
// -----------------------------------------------------------------------------
// soc_boot_loader
// Purpose : streams a program image from a valid/ready source into the
//           instruction ROM write port while holding the core in reset, then
//           releases the core. Checks image length, stalls (timeout) and,
//           optionally, an image checksum. A new start in RUN/ERROR reloads.
// Ports   : clk           clock, rising edge
//           rst           asynchronous active-low reset
//           start_i       load request, sampled every cycle in IDLE/RUN/ERROR
//           len_i         image length in words, latched with start
//           exp_sum_i     expected image checksum, latched with start
//           bus           soc_boot_loader_if.slave: stream in, ROM write out
//           core_rst_n_o  core reset (active-low), high only in RUN
//           busy_o        LOAD or CHECK
//           done_o        image loaded, core running
//           err_o         load failed
//           err_code_o    01 bad length, 10 timeout, 11 checksum, 00 none
// Config  : `define LOADER_CHECKSUM_EN to enable the checksum comparison in
//           CHECK. Without it exp_sum_i is ignored and CHECK always passes.
// -----------------------------------------------------------------------------
module soc_boot_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 65535,
  parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   exp_sum_i,
  soc_boot_loader_if.slave    bus,
  output logic                core_rst_n_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_SUM  = 2'b11;

  // Timer only has to reach TIMEOUT-1.
  localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_err_code;
  logic [1:0]          w_err_code_next;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_idx;
  logic [TMR_W-1:0]    r_timer;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic                w_start;
  logic                w_ready;
  logic                w_beat;
  logic                w_last;
  logic                w_timeout;
  logic                w_len_bad;
  logic                w_sum_ok;
  logic [ADDR_W-1:0]   w_word_addr;

  assign w_last      = (r_idx == (r_len - CNT_W'(1)));
  assign w_len_bad   = (len_i == '0) || (len_i > CNT_W'(DEPTH));
  assign w_word_addr = BASE_ADDR + ADDR_W'({r_idx, 2'b00});

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_exp_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum     <= '0;
      r_exp_sum <= '0;
    end else if (w_start) begin
      r_sum     <= '0;
      r_exp_sum <= exp_sum_i;
    end else if (w_beat) begin
      r_sum     <= r_sum + bus.s_data_i;
    end
  end

  // In CHECK the last word has already been folded into r_sum.
  assign w_sum_ok = (r_sum == r_exp_sum);
`else
  logic w_unused_exp_sum;
  assign w_unused_exp_sum = ^exp_sum_i;
  assign w_sum_ok         = 1'b1;
`endif

  // Next state, decoded outputs and handshake.
  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = r_err_code;
    w_start         = 1'b0;
    w_ready         = (r_state == ST_LOAD);
    w_beat          = bus.s_valid_i & w_ready;
    // A stall cycle is one without a beat; the beat itself restarts the count.
    w_timeout       = (TIMEOUT != 0) && (r_timer == TMR_LAST) && !w_beat;
    busy_o          = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    done_o          = (r_state == ST_RUN);
    err_o           = (r_state == ST_ERROR);
    core_rst_n_o    = (r_state == ST_RUN);

    unique case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_i) begin
          w_start = 1'b1;
          if (w_len_bad) begin
            w_state_next    = ST_ERROR;
            w_err_code_next = ERR_LEN;
          end else begin
            w_state_next    = ST_LOAD;
            w_err_code_next = ERR_NONE;
          end
        end
      end
      ST_LOAD: begin
        if (w_beat && w_last) begin
          w_state_next = ST_CHECK;
        end else if (w_timeout) begin
          w_state_next    = ST_ERROR;
          w_err_code_next = ERR_TMO;
        end
      end
      ST_CHECK: begin
        if (w_sum_ok) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next    = ST_ERROR;
          w_err_code_next = ERR_SUM;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_len      <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_err_code <= w_err_code_next;
      // Write strobe follows each accepted beat by exactly one cycle.
      r_wen      <= w_beat;
      if (w_start) begin
        r_len   <= len_i;
        r_idx   <= '0;
        r_timer <= '0;
      end else if (w_beat) begin
        r_addr  <= w_word_addr;
        r_data  <= bus.s_data_i;
        r_idx   <= r_idx + CNT_W'(1);
        r_timer <= '0;
      end else if (r_state == ST_LOAD) begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  assign bus.s_ready_o  = w_ready;
  assign bus.rom_wen_o  = r_wen;
  assign bus.rom_addr_o = r_addr;
  assign bus.rom_data_o = r_data;
  assign err_code_o     = r_err_code;

endmodule

// File: tb/tb_soc_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_soc_boot_loader
// Two loaders share one stimulus stream:
//   A: BASE_ADDR 0x000, TIMEOUT 65535
//   B: BASE_ADDR 0x100, TIMEOUT 8
// A behavioural model predicts every output of both loaders each cycle; a
// compare process checks them on the falling edge. Directed scenarios add
// literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_soc_boot_loader;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_CHECK = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_ERR   = 4;

  typedef struct packed {
    logic          ready;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          core;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    code;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic [DW-1:0] exp_sum;
  logic          s_valid;
  logic [DW-1:0] s_data;

  logic          core_a, busy_a, done_a, err_a;
  logic          core_b, busy_b, done_b, err_b;
  logic [1:0]    code_a, code_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  wr_t wlog_a[$];
  wr_t wlog_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  soc_boot_loader_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  soc_boot_loader_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  assign ifa.s_valid_i = s_valid;
  assign ifa.s_data_i  = s_data;
  assign ifb.s_valid_i = s_valid;
  assign ifb.s_data_i  = s_data;

  soc_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len), .exp_sum_i(exp_sum), .bus(ifa),
    .core_rst_n_o(core_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_code_o(code_a)
  );

  soc_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(32'h100), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len), .exp_sum_i(exp_sum), .bus(ifb),
    .core_rst_n_o(core_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_code_o(code_b)
  );

  obs_t oa, ob;
  always_comb begin
    oa = '{ready: ifa.s_ready_o, wen: ifa.rom_wen_o, addr: ifa.rom_addr_o, data: ifa.rom_data_o,
           core: core_a, busy: busy_a, done: done_a, err: err_a, code: code_a};
    ob = '{ready: ifb.s_ready_o, wen: ifb.rom_wen_o, addr: ifb.rom_addr_o, data: ifb.rom_data_o,
           core: core_b, busy: busy_b, done: done_b, err: err_b, code: code_b};
  end

  // ---------------------------------------------------------------- model
  int          m_phase[2];
  int          m_len[2];
  int          m_got[2];
  int          m_quiet[2];
  int          m_code[2];
  bit          m_wen[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_data[2];
  logic [31:0] m_sum[2];
  logic [31:0] m_exp[2];

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h100;
  endfunction

  function automatic int timeout_of(input int d);
    return (d == 0) ? 65535 : 8;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit acc;
    bit sum_ok;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_phase[d] = PH_IDLE; m_len[d] = 0; m_got[d] = 0; m_quiet[d] = 0; m_code[d] = 0;
        m_wen[d] = 1'b0; m_addr[d] = '0; m_data[d] = '0; m_sum[d] = '0; m_exp[d] = '0;
      end else begin
        acc = s_valid && (m_phase[d] == PH_LOAD);
        m_wen[d] = acc;
        case (m_phase[d])
          PH_IDLE, PH_RUN, PH_ERR: begin
            if (start) begin
              m_len[d] = int'(len); m_got[d] = 0; m_quiet[d] = 0;
              m_sum[d] = '0; m_exp[d] = exp_sum;
              if (m_len[d] == 0 || m_len[d] > DEPTH) begin
                m_phase[d] = PH_ERR; m_code[d] = 1;
              end else begin
                m_phase[d] = PH_LOAD; m_code[d] = 0;
              end
            end
          end
          PH_LOAD: begin
            if (acc) begin
              m_addr[d] = base_of(d) + 32'(4 * m_got[d]);
              m_data[d] = s_data;
              m_sum[d]  = m_sum[d] + s_data;
              m_got[d]++;
              m_quiet[d] = 0;
              if (m_got[d] == m_len[d]) m_phase[d] = PH_CHECK;
            end else begin
              m_quiet[d]++;
              if (timeout_of(d) != 0 && m_quiet[d] == timeout_of(d)) begin
                m_phase[d] = PH_ERR; m_code[d] = 2;
              end
            end
          end
          PH_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            sum_ok = (m_sum[d] == m_exp[d]);
`else
            sum_ok = 1'b1;
`endif
            if (sum_ok) m_phase[d] = PH_RUN;
            else begin m_phase[d] = PH_ERR; m_code[d] = 3; end
          end
          default: m_phase[d] = PH_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic cmp(input int d, input obs_t o);
    string p;
    p = (d == 0) ? "A" : "B";
    check({p, ".s_ready"},  32'(o.ready), 32'(m_phase[d] == PH_LOAD));
    check({p, ".rom_wen"},  32'(o.wen),   32'(m_wen[d]));
    check({p, ".rom_addr"}, o.addr,       m_addr[d]);
    check({p, ".rom_data"}, o.data,       m_data[d]);
    check({p, ".core_rst_n"}, 32'(o.core), 32'(m_phase[d] == PH_RUN));
    check({p, ".busy"},     32'(o.busy),  32'(m_phase[d] == PH_LOAD || m_phase[d] == PH_CHECK));
    check({p, ".done"},     32'(o.done),  32'(m_phase[d] == PH_RUN));
    check({p, ".err"},      32'(o.err),   32'(m_phase[d] == PH_ERR));
    check({p, ".err_code"}, 32'(o.code),  32'(m_code[d]));
    if (o.wen === 1'b1) begin
      $display("rom write %s addr=0x%08h data=0x%08h cyc=%0d", p, o.addr, o.data, cyc);
      if (d == 0) wlog_a.push_back('{addr: o.addr, data: o.data, cyc: cyc});
      else        wlog_b.push_back('{addr: o.addr, data: o.data, cyc: cyc});
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, oa);
      cmp(1, ob);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int n, input logic [31:0] es = 32'h0);
    start = 1'b1; len = CW'(n); exp_sum = es;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    s_valid = 1'b1; s_data = w;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic clear_logs();
    wlog_a.delete();
    wlog_b.delete();
  endtask

  initial begin : stim
    int c0;
    logic [31:0] w4[4];
    rst = 1'b1; start = 1'b0; len = '0; exp_sum = '0; s_valid = 1'b0; s_data = '0;
    #3 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    check("reset.core_rst_n", 32'(core_a), 32'h0);
    check("reset.busy_done_err", {29'h0, busy_b, done_b, err_b}, 32'h0);

    // 1: four words back-to-back
    w4 = '{32'h11, 32'h22, 32'h33, 32'h44};
    clear_logs();
    do_start(4);
    c0 = cyc;
    foreach (w4[i]) send(w4[i]);
    check("t1.last_write_in_check", {30'h0, busy_a, ifa.rom_wen_o}, 32'h3);
    check("t1.last_addr_b", ifb.rom_addr_o, 32'h10C);
    tick();
    check("t1.done_core", {30'h0, done_a, core_a}, 32'h3);
    check("t1.nwrites", wlog_a.size(), 4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      check($sformatf("t1.addr%0d", i), wlog_a[i].addr, 32'(4 * i));
      check($sformatf("t1.data%0d", i), wlog_a[i].data, w4[i]);
      check($sformatf("t1.cyc%0d", i), wlog_a[i].cyc, c0 + 1 + i);
    end

    // 2: reload from RUN, len 2 with 3 idle cycles between beats
    clear_logs();
    do_start(2);
    check("t2.core_falls", {30'h0, core_a, core_b}, 32'h0);
    send(32'hA5A5_0001);
    tick(3);
    check("t2.ready_in_gap", 32'(ifb.s_ready_o), 32'h1);
    send(32'h5A5A_0002);
    check("t2.ready_after_last", 32'(ifb.s_ready_o), 32'h0);
    tick();
    check("t2.done_b", 32'(done_b), 32'h1);
    check("t2.nwrites_b", wlog_b.size(), 2);
    if (wlog_b.size() == 2) begin
      check("t2.addr0", wlog_b[0].addr, 32'h100);
      check("t2.addr1", wlog_b[1].addr, 32'h104);
      check("t2.data1", wlog_b[1].data, 32'h5A5A_0002);
    end

    // 3: bad lengths, then the largest legal one
    clear_logs();
    do_start(0);
    check("t3.len0", {29'h0, err_a, code_a}, 32'h5);
    tick(2);
    do_start(DEPTH + 1);
    check("t3.lenmax1", {29'h0, err_b, code_b}, 32'h5);
    check("t3.nowrites", wlog_a.size() + wlog_b.size(), 0);
    do_start(DEPTH);
    check("t3.lendepth", {29'h0, busy_a, code_a}, 32'h4);

    // 4: one beat then stall; B times out exactly 8 cycles after the beat
    do_reset();
    do_start(3);
    send(32'h77);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t4.code_k%0d", k), 32'(code_b), (k == 8) ? 32'h2 : 32'h0);
      check($sformatf("t4.core_k%0d", k), 32'(core_b), 32'h0);
    end
    check("t4.a_still_busy", 32'(busy_a), 32'h1);

    // 5: checksum mismatch then match
    do_reset();
    do_start(3, 32'h6);
    send(32'h1); send(32'h2); send(32'h4);
    tick();
`ifdef LOADER_CHECKSUM_EN
    check("t5.bad_sum", {29'h0, err_a, code_a}, 32'h7);
`else
    check("t5.sum_ignored", 32'(done_a), 32'h1);
`endif
    do_start(3, 32'h7);
    send(32'h1); send(32'h2); send(32'h4);
    tick();
    check("t5.good_sum", {30'h0, done_a, done_b}, 32'h3);

    // 6: asynchronous reset in the middle of a load
    do_reset();
    do_start(4);
    send(32'h10);
    send(32'h20);
    check("t6.wen_before", 32'(ifa.rom_wen_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("t6.async_ctrl", {26'h0, ifa.s_ready_o, ifa.rom_wen_o, core_a, busy_a, done_a, err_a}, 32'h0);
    check("t6.async_code", 32'(code_a), 32'h0);
    check("t6.async_addr", ifa.rom_addr_o, 32'h0);
    check("t6.async_data", ifa.rom_data_o, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("t6.idle", {29'h0, busy_b, done_b, err_b}, 32'h0);
    clear_logs();
    do_start(1);
    send(32'h99);
    tick();
    check("t6.reload_done", {30'h0, done_a, done_b}, 32'h3);
    check("t6.nwrites", wlog_b.size(), 1);
    if (wlog_b.size() == 1) check("t6.addr_b", wlog_b[0].addr, 32'h100);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
